// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: single-outstanding word
// fetch over a valid/ready request channel, 1-entry hold buffer, redirect drain.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Stall_F,
    input  logic        Flush_D,
    input  logic        PC_Redirect_En_E,
    input  logic [31:0] PC_Target_E,
    output logic        IMEM_Req_Valid,
    input  logic        IMEM_Req_Ready,
    output logic [31:0] IMEM_Req_Addr,
    input  logic        IMEM_Resp_Valid,
    input  logic [31:0] IMEM_Resp_Data,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus_4_D,
    output logic        Valid_D
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_f_r;
    logic [31:0] pc_f_next_s;
    logic [31:0] hold_instr_r;
    logic [31:0] hold_instr_next_s;
    logic [31:0] hold_pc_r;
    logic [31:0] hold_pc_next_s;

    logic        req_valid_s;
    logic        accept_s;
    logic [31:0] target_s;
    logic        load_ifid_s;
    logic [31:0] load_instr_s;
    logic [31:0] load_pc_s;

    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc_plus_4_d_r;
    logic        valid_d_r;

    logic        target_lsb_unused_s;

    assign req_valid_s         = (state_r == S_REQ);
    assign accept_s            = req_valid_s && IMEM_Req_Ready;
    assign target_s            = {PC_Target_E[31:2], 2'b00};
    assign target_lsb_unused_s = ^PC_Target_E[1:0];

    // Request channel: valid is forced low for the whole time reset is held.
    assign IMEM_Req_Valid = req_valid_s && RST_N;
    assign IMEM_Req_Addr  = pc_f_r;

    assign Instr_D     = instr_d_r;
    assign PC_D        = pc_d_r;
    assign PC_Plus_4_D = pc_plus_4_d_r;
    assign Valid_D     = valid_d_r;

    // Fetch FSM next-state, PC, hold buffer and IF/ID load selection.
    always_comb begin
        state_next_s      = state_r;
        pc_f_next_s       = pc_f_r;
        hold_instr_next_s = hold_instr_r;
        hold_pc_next_s    = hold_pc_r;
        load_ifid_s       = 1'b0;
        load_instr_s      = NOP_INSTR;
        load_pc_s         = pc_f_r;

        case (state_r)
            S_REQ: begin
                if (PC_Redirect_En_E) begin
                    pc_f_next_s       = target_s;
                    hold_instr_next_s = 32'h0000_0000;
                    hold_pc_next_s    = 32'h0000_0000;
                    // An accepted request to the old PC is still in flight.
                    state_next_s      = accept_s ? S_DRAIN : S_REQ;
                end else if (accept_s) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (PC_Redirect_En_E) begin
                    pc_f_next_s       = target_s;
                    hold_instr_next_s = 32'h0000_0000;
                    hold_pc_next_s    = 32'h0000_0000;
                    state_next_s      = IMEM_Resp_Valid ? S_REQ : S_DRAIN;
                end else if (IMEM_Resp_Valid) begin
                    pc_f_next_s = pc_f_r + 32'd4;
                    if (Flush_D) begin
                        state_next_s = S_REQ;
                    end else if (!Stall_F) begin
                        load_ifid_s  = 1'b1;
                        load_instr_s = IMEM_Resp_Data;
                        load_pc_s    = pc_f_r;
                        state_next_s = S_REQ;
                    end else begin
                        hold_instr_next_s = IMEM_Resp_Data;
                        hold_pc_next_s    = pc_f_r;
                        state_next_s      = S_HOLD;
                    end
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (PC_Redirect_En_E) begin
                    pc_f_next_s       = target_s;
                    hold_instr_next_s = 32'h0000_0000;
                    hold_pc_next_s    = 32'h0000_0000;
                    state_next_s      = S_REQ;
                end else if (Flush_D) begin
                    // A squashed decode slot also squashes the instruction waiting for it.
                    hold_instr_next_s = 32'h0000_0000;
                    hold_pc_next_s    = 32'h0000_0000;
                    state_next_s      = S_REQ;
                end else if (!Stall_F) begin
                    load_ifid_s       = 1'b1;
                    load_instr_s      = hold_instr_r;
                    load_pc_s         = hold_pc_r;
                    hold_instr_next_s = 32'h0000_0000;
                    hold_pc_next_s    = 32'h0000_0000;
                    state_next_s      = S_REQ;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (PC_Redirect_En_E) begin
                    pc_f_next_s = target_s;
                end else begin
                    pc_f_next_s = pc_f_r;
                end
                // The stale response closes the drain even if a new redirect lands with it.
                if (IMEM_Resp_Valid) begin
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            default: begin
                state_next_s = S_REQ;
            end
        endcase
    end

    // Fetch state, PC_F and hold buffer registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= S_REQ;
            pc_f_r       <= RESET_PC;
            hold_instr_r <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
        end else begin
            state_r      <= state_next_s;
            pc_f_r       <= pc_f_next_s;
            hold_instr_r <= hold_instr_next_s;
            hold_pc_r    <= hold_pc_next_s;
        end
    end

    // IF/ID pipeline register: flush beats load, stall holds everything.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            instr_d_r     <= NOP_INSTR;
            pc_d_r        <= 32'h0000_0000;
            pc_plus_4_d_r <= 32'h0000_0000;
            valid_d_r     <= 1'b0;
        end else if (Flush_D) begin
            instr_d_r     <= NOP_INSTR;
            pc_d_r        <= pc_d_r;
            pc_plus_4_d_r <= pc_plus_4_d_r;
            valid_d_r     <= 1'b0;
        end else if (load_ifid_s) begin
            instr_d_r     <= load_instr_s;
            pc_d_r        <= load_pc_s;
            pc_plus_4_d_r <= load_pc_s + 32'd4;
            valid_d_r     <= 1'b1;
        end else if (!Stall_F) begin
            instr_d_r     <= NOP_INSTR;
            pc_d_r        <= pc_d_r;
            pc_plus_4_d_r <= pc_plus_4_d_r;
            valid_d_r     <= 1'b0;
        end else begin
            instr_d_r     <= instr_d_r;
            pc_d_r        <= pc_d_r;
            pc_plus_4_d_r <= pc_plus_4_d_r;
            valid_d_r     <= valid_d_r;
        end
    end

endmodule
